wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  Write-back end of the MEM/WB interface: 32x32 general register file.
//  The WB stage writes it; ID reads it through two combinational ports with same-cycle WB->ID bypass.
//  Array is not async-reset. After reset a sweep clears one register per cycle and stalls the pipeline meanwhile.
// PARAMETERS
//  REG_NUM   32  number of architectural registers (power of 2)
//  ADDR_W    5   register index width, log2(REG_NUM)
//  DATA_W    32  register data width
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       asynchronous, active-low reset (0 = reset asserted)
//  we         in   1       write enable from WB (wb_reg_we)
//  waddr      in   ADDR_W  write index from WB (wb_waddr)
//  wdata      in   DATA_W  write data from WB (wb_data)
//  re1        in   1       read enable, port 1
//  raddr1     in   ADDR_W  read index, port 1
//  rdata1     out  DATA_W  read data, port 1 (combinational)
//  re2        in   1       read enable, port 2
//  raddr2     in   ADDR_W  read index, port 2
//  rdata2     out  DATA_W  read data, port 2 (combinational)
//  stall_req  out  1       1 = pipeline must hold (clear sweep running)
//  init_done  out  1       1 = array valid, normal operation
// BEHAVIOUR
//  - States: INIT, RUN. rst==0 (async): state<=INIT, clr_cnt<=0. Outputs in reset: stall_req=1, init_done=0, rdata1=rdata2=0.
//  - INIT: each rising edge regs[clr_cnt]<=0 and clr_cnt<=clr_cnt+1. At clr_cnt==REG_NUM-1 the edge clears the last register and sets state<=RUN.
//    Sweep lasts exactly REG_NUM edges after rst deasserts. clr_cnt wraps to 0 and is unused in RUN.
//  - stall_req = (state==INIT); init_done = (state==RUN). Both are decoded from registered state.
//  - INIT: WB writes are dropped, since the pipeline is held and a write is a protocol violation. Reads return 0.
//  - RUN write: on rising edge, if we==1 && waddr!=0 then regs[waddr]<=wdata. Writes to r0 are discarded.
//  - RUN read, per port n, priority order:
//    re_n==0 -> 0; raddr_n==0 -> 0;
//    we==1 && waddr==raddr_n -> wdata (bypass, same cycle);
//    else regs[raddr_n].
//  - Both ports may read the same index, and both may bypass simultaneously.
//  - Read latency 0 (combinational). Write visible to same-cycle reads via bypass and to array reads from the next cycle.
//  - Reset mid-RUN: contents are discarded and INIT restarts from 0. Reset mid-INIT restarts the counter at 0.
//  - No X on outputs after reset, even before the sweep completes.
// STRUCTURE
//  - defines.v holds `RegBus, `RegAddrBus, `RegNum, `RegNumLog2, `ZeroWord, `NOPRegAddr, `WriteEnable, `ReadEnable.
//    Add there `RstActiveN (1'b0) and state encodings `RfInit / `RfRun.
//  - Sub-module regfile_clear_ctrl contains the INIT/RUN FSM and clr_cnt.
//    Its outputs are clr_we, clr_addr, stall_req and init_done.
//  - Top module muxes clr_* and WB writes into the single array write port, and holds the read/bypass logic.
// TESTING
//  1. Release rst at t0 -> stall_req=1 for exactly 32 edges, init_done rises after 32nd edge; re1=1 raddr1=5 -> rdata1=0 throughout.
//  2. RUN: we=1 waddr=3 wdata=0x12345678 for one edge, then re1=1 raddr1=3 -> rdata1=0x12345678; re2=1 raddr2=3 -> same.
//  3. Bypass: same cycle we=1 waddr=7 wdata=0xDEADBEEF, re1=1 raddr1=7 -> rdata1=0xDEADBEEF; re2=0 raddr2=7 -> rdata2=0.
//  4. r0: we=1 waddr=0 wdata=0xFFFFFFFF with re1=1 raddr1=0 -> rdata1=0 same cycle and after the edge.
//  5. Reset mid-RUN: write r9=0xA5A5A5A5, pulse rst low 1 cycle -> stall_req=1 for 32 edges; then read r9 -> 0.
//  6. Write during INIT: we=1 waddr=31 wdata=0x1 at sweep edge 2 -> after init_done, read r31 -> 0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared constants and types for the write-back register file and its clear sweep.
// Widths here are the architectural defaults; modules take them as parameter defaults.
package wb_regfile_pkg;

    localparam int REG_NUM      = 32;
    localparam int REG_NUM_LOG2 = 5;
    localparam int DATA_W       = 32;

    localparam logic                    RST_ACTIVE_N = 1'b0;
    localparam logic                    WRITE_ENABLE = 1'b1;
    localparam logic                    READ_ENABLE  = 1'b1;
    localparam logic [DATA_W-1:0]       ZERO_WORD    = {DATA_W{1'b0}};
    localparam logic [REG_NUM_LOG2-1:0] NOP_REG_ADDR = {REG_NUM_LOG2{1'b0}};

    typedef enum logic [0:0] {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_e;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_clear_ctrl.sv
// Post-reset clear sequencer: walks every register index once, holding the pipeline,
// then hands the array over to normal write-back operation.
module wb_regfile_clear_ctrl
    import wb_regfile_pkg::*;
#(
    parameter int REG_NUM = wb_regfile_pkg::REG_NUM,
    parameter int ADDR_W  = wb_regfile_pkg::REG_NUM_LOG2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              stall_req,
    output logic              init_done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_NUM - 1);
    localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              stall_q, stall_d;
    logic              done_q, done_d;

    // State, sweep counter and status flags; status is registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE_N) begin
            state_q   <= RF_INIT;
            clr_cnt_q <= {ADDR_W{1'b0}};
            stall_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            stall_q   <= stall_d;
            done_q    <= done_d;
        end
    end

    // Next state: the edge that clears the last index also enters RUN; the counter wraps to 0.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            RF_INIT: begin
                clr_cnt_d = clr_cnt_q + CNT_ONE;
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = RF_RUN;
                end else begin
                    state_d = RF_INIT;
                end
            end
            RF_RUN: begin
                state_d   = RF_RUN;
                clr_cnt_d = clr_cnt_q;
            end
            default: begin
                state_d   = RF_INIT;
                clr_cnt_d = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Output decode: clear strobe from current state, status flags precomputed from next state.
    always_comb begin
        clr_we   = 1'b0;
        clr_addr = clr_cnt_q;
        stall_d  = 1'b1;
        done_d   = 1'b0;
        if (state_q == RF_INIT) begin
            clr_we = 1'b1;
        end else begin
            clr_we = 1'b0;
        end
        if (state_d == RF_RUN) begin
            stall_d = 1'b0;
            done_d  = 1'b1;
        end else begin
            stall_d = 1'b1;
            done_d  = 1'b0;
        end
    end

    assign stall_req = stall_q;
    assign init_done = done_q;

endmodule : wb_regfile_clear_ctrl

// File: rtl/wb_regfile.sv
// 32x32 general register file at the MEM/WB boundary: one write port shared by the clear
// sweep and WB, two combinational ID read ports with same-cycle WB bypass.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int REG_NUM = wb_regfile_pkg::REG_NUM,
    parameter int ADDR_W  = wb_regfile_pkg::REG_NUM_LOG2,
    parameter int DATA_W  = wb_regfile_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              stall_req,
    output logic              init_done
);

    logic [DATA_W-1:0] regs_q [REG_NUM];

    logic              clr_we_s;
    logic [ADDR_W-1:0] clr_addr_s;
    logic              init_done_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;

    // Read mux for one port; array contents are only trusted once the sweep has finished.
    function automatic logic [DATA_W-1:0] read_port(
        input logic              valid,
        input logic              re,
        input logic [ADDR_W-1:0] raddr,
        input logic              wb_we,
        input logic [ADDR_W-1:0] wb_addr,
        input logic [DATA_W-1:0] wb_data,
        input logic [DATA_W-1:0] arr_data
    );
        logic [DATA_W-1:0] rd;
        if (!valid) begin
            rd = {DATA_W{1'b0}};
        end else if (re != READ_ENABLE) begin
            rd = {DATA_W{1'b0}};
        end else if (raddr == {ADDR_W{1'b0}}) begin
            rd = {DATA_W{1'b0}};
        end else if ((wb_we == WRITE_ENABLE) && (wb_addr == raddr)) begin
            rd = wb_data;
        end else begin
            rd = arr_data;
        end
        return rd;
    endfunction

    wb_regfile_clear_ctrl #(
        .REG_NUM (REG_NUM),
        .ADDR_W  (ADDR_W)
    ) u_clear_ctrl (
        .clk       (clk),
        .rst       (rst),
        .clr_we    (clr_we_s),
        .clr_addr  (clr_addr_s),
        .stall_req (stall_req),
        .init_done (init_done_s)
    );

    assign init_done = init_done_s;

    // Write-port arbitration: sweep owns the port in INIT, so WB writes then are dropped.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = {ADDR_W{1'b0}};
        wr_data_s = {DATA_W{1'b0}};
        if (clr_we_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = clr_addr_s;
            wr_data_s = {DATA_W{1'b0}};
        end else if (init_done_s && (we == WRITE_ENABLE) && (waddr != {ADDR_W{1'b0}})) begin
            wr_en_s   = 1'b1;
            wr_addr_s = waddr;
            wr_data_s = wdata;
        end else begin
            wr_en_s   = 1'b0;
            wr_addr_s = {ADDR_W{1'b0}};
            wr_data_s = {DATA_W{1'b0}};
        end
    end

    // Storage array; deliberately has no reset, the sweep provides the known state.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            regs_q[wr_addr_s] <= wr_data_s;
        end else begin
            regs_q[wr_addr_s] <= regs_q[wr_addr_s];
        end
    end

    // Combinational read ports with WB bypass.
    always_comb begin
        rdata1 = read_port(init_done_s, re1, raddr1, we, waddr, wdata, regs_q[raddr1]);
        rdata2 = read_port(init_done_s, re2, raddr2, we, waddr, wdata, regs_q[raddr2]);
    end

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: reset sweep, writes, bypass, r0 and resets.
`timescale 1ns/1ps
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        stall_req;
    logic        init_done;

    int tests;
    int fails;

    wb_regfile dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .re1       (re1),
        .raddr1    (raddr1),
        .rdata1    (rdata1),
        .re2       (re2),
        .raddr2    (raddr2),
        .rdata2    (rdata2),
        .stall_req (stall_req),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts rising edges while stall_req is high, bounded; called at a negedge after release.
    task automatic count_stall_edges(output int n);
        n = 0;
        while (stall_req === 1'b1 && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; waddr = a; wdata = d;
        @(negedge clk);
        we = 1'b0; waddr = 5'd0; wdata = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        we = 1'b1; waddr = 5'd5; wdata = 32'h0000_0055;
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
        @(negedge clk); @(negedge clk);
        #1;
        tests++; if (stall_req !== 1'b1) begin fails++; $display("FAIL reset_stall got %b want 1", stall_req); end
        tests++; if (init_done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", init_done); end
        tests++; if (rdata1 !== 32'h0) begin fails++; $display("FAIL reset_rdata1 got %h want 0", rdata1); end
        tests++; if (rdata2 !== 32'h0) begin fails++; $display("FAIL reset_rdata2 got %h want 0", rdata2); end
        we = 1'b0; waddr = 5'd0; wdata = 32'h0; re2 = 1'b0;
    endtask

    task automatic test_sweep();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            #1;
            tests++;
            if (stall_req !== 1'b1 || init_done !== 1'b0 || rdata1 !== 32'h0) begin
                fails++;
                $display("FAIL sweep_edge%0d got stall=%b done=%b rdata1=%h want 1/0/0", k, stall_req, init_done, rdata1);
            end
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL sweep_end_stall got %b want 0", stall_req); end
        tests++; if (init_done !== 1'b1) begin fails++; $display("FAIL sweep_end_done got %b want 1", init_done); end
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            #1;
            tests++;
            if (rdata1 !== 32'h0) begin fails++; $display("FAIL cleared_r%0d got %h want 0", i, rdata1); end
        end
    endtask

    task automatic test_write_read();
        write_reg(5'd3, 32'h1234_5678);
        write_reg(5'd31, 32'h0F0F_0F0F);
        write_reg(5'd1, 32'h8000_0001);
        re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd3;
        #1;
        tests++; if (rdata1 !== 32'h1234_5678) begin fails++; $display("FAIL wr_r3_p1 got %h want 12345678", rdata1); end
        tests++; if (rdata2 !== 32'h1234_5678) begin fails++; $display("FAIL wr_r3_p2 got %h want 12345678", rdata2); end
        raddr1 = 5'd31; raddr2 = 5'd1;
        #1;
        tests++; if (rdata1 !== 32'h0F0F_0F0F) begin fails++; $display("FAIL wr_r31 got %h want 0f0f0f0f", rdata1); end
        tests++; if (rdata2 !== 32'h8000_0001) begin fails++; $display("FAIL wr_r1 got %h want 80000001", rdata2); end
        re1 = 1'b0; raddr1 = 5'd3;
        #1;
        tests++; if (rdata1 !== 32'h0) begin fails++; $display("FAIL re1_off got %h want 0", rdata1); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        we = 1'b1; waddr = 5'd7; wdata = 32'hDEAD_BEEF;
        re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b0; raddr2 = 5'd7;
        #1;
        tests++; if (rdata1 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL byp_p1 got %h want deadbeef", rdata1); end
        tests++; if (rdata2 !== 32'h0) begin fails++; $display("FAIL byp_p2_disabled got %h want 0", rdata2); end
        re2 = 1'b1;
        #1;
        tests++; if (rdata2 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL byp_both got %h want deadbeef", rdata2); end
        @(negedge clk);
        we = 1'b1; waddr = 5'd3; wdata = 32'hCAFE_F00D;
        raddr1 = 5'd3; raddr2 = 5'd7;
        #1;
        tests++; if (rdata1 !== 32'hCAFE_F00D) begin fails++; $display("FAIL byp_over_old got %h want cafef00d", rdata1); end
        tests++; if (rdata2 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL arr_r7 got %h want deadbeef", rdata2); end
        @(negedge clk);
        we = 1'b0; waddr = 5'd0; wdata = 32'h0;
        #1;
        tests++; if (rdata1 !== 32'hCAFE_F00D) begin fails++; $display("FAIL arr_r3_new got %h want cafef00d", rdata1); end
    endtask

    task automatic test_r0();
        @(negedge clk);
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        re1 = 1'b1; raddr1 = 5'd0;
        #1;
        tests++; if (rdata1 !== 32'h0) begin fails++; $display("FAIL r0_same_cycle got %h want 0", rdata1); end
        @(negedge clk);
        we = 1'b0; wdata = 32'h0;
        #1;
        tests++; if (rdata1 !== 32'h0) begin fails++; $display("FAIL r0_after got %h want 0", rdata1); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        write_reg(5'd9, 32'hA5A5_A5A5);
        re1 = 1'b1; raddr1 = 5'd9;
        #1;
        tests++; if (rdata1 !== 32'hA5A5_A5A5) begin fails++; $display("FAIL r9_before got %h want a5a5a5a5", rdata1); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        #1;
        tests++; if (stall_req !== 1'b1) begin fails++; $display("FAIL midrun_stall got %b want 1", stall_req); end
        count_stall_edges(n);
        tests++; if (n != 32) begin fails++; $display("FAIL midrun_sweep_len got %0d want 32", n); end
        #1;
        tests++; if (rdata1 !== 32'h0) begin fails++; $display("FAIL r9_after got %h want 0", rdata1); end
    endtask

    task automatic test_reset_mid_init();
        int n;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        count_stall_edges(n);
        tests++; if (n != 32) begin fails++; $display("FAIL midinit_sweep_len got %0d want 32", n); end
        tests++; if (init_done !== 1'b1) begin fails++; $display("FAIL midinit_done got %b want 1", init_done); end
    endtask

    task automatic test_write_during_init();
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        re1 = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            if (k == 2) begin
                we = 1'b1; waddr = 5'd31; wdata = 32'h0000_0001; raddr1 = 5'd31;
                #1;
                tests++; if (rdata1 !== 32'h0) begin fails++; $display("FAIL init_bypass got %h want 0", rdata1); end
            end else if (k == 10) begin
                we = 1'b1; waddr = 5'd1; wdata = 32'h0000_0001; raddr1 = 5'd1;
            end else begin
                we = 1'b0; waddr = 5'd0; wdata = 32'h0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        we = 1'b0; waddr = 5'd0; wdata = 32'h0;
        #1;
        tests++; if (init_done !== 1'b1) begin fails++; $display("FAIL init_wr_done got %b want 1", init_done); end
        raddr1 = 5'd31;
        #1;
        tests++; if (rdata1 !== 32'h0) begin fails++; $display("FAIL init_wr_r31 got %h want 0", rdata1); end
        raddr1 = 5'd1;
        #1;
        tests++; if (rdata1 !== 32'h0) begin fails++; $display("FAIL init_wr_r1 got %h want 0", rdata1); end
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b0; we = 1'b0; waddr = 5'd0; wdata = 32'h0;
        re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;
        test_reset();
        test_sweep();
        test_write_read();
        test_bypass();
        test_r0();
        test_reset_mid_run();
        test_reset_mid_init();
        test_write_during_init();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_wb_regfile
